// File: rtl/down_counter_2d_rd.sv
// Read-side address sequencer: walks a ROWS x COLS tile from bottom-right to
// top-left, one address per accepted valid/ready beat, and pulses done at the end.
module down_counter_2d_rd #(
  parameter int ROWS      = 14,
  parameter int COLS      = 14,
  parameter int ROW_W     = 4,
  parameter int COL_W     = 4,
  parameter int STRIDE    = 1,
  parameter int ROW_PITCH = 14,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [ROW_W-1:0]  row_o,
  output logic [COL_W-1:0]  col_o,
  output logic              last_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [ROW_W-1:0]  ROW_TOP  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0]  COL_TOP  = COL_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] PITCH_A  = ADDR_W'(ROW_PITCH);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);

  state_t            state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              at_end, beat;

  assign at_end = (row_q == '0) && (col_q == '0);
  assign beat   = (state_q == S_RUN) && ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN;
      S_RUN:   if (beat && at_end) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counters only move on an accepted beat; the final beat leaves them at 0/0.
  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    base_d = base_q;
    if (state_q == S_IDLE && start_i) begin
      row_d  = ROW_TOP;
      col_d  = COL_TOP;
      base_d = base_i;
    end else if (beat && !at_end) begin
      if (col_q != '0) begin
        col_d = col_q - 1'b1;
      end else begin
        col_d = COL_TOP;
        row_d = row_q - 1'b1;
      end
    end
  end

  always_comb begin
    valid_o = (state_q == S_RUN);
    busy_o  = (state_q == S_RUN) || (state_q == S_DONE);
    done_o  = (state_q == S_DONE);
    last_o  = (state_q == S_RUN) && at_end;
    row_o   = row_q;
    col_o   = col_q;
    // Modulo-2^ADDR_W arithmetic; overflow wraps silently.
    addr_o  = base_q + ADDR_W'(row_q) * PITCH_A + ADDR_W'(col_q) * STRIDE_A;
  end

endmodule

// File: tb/tb_down_counter_2d_rd.sv
// Bench for down_counter_2d_rd: four configurations muxed onto one observation
// port, checked beat-by-beat against a queue of expected addresses.
module tb_down_counter_2d_rd;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 0: 2x3 pitch 3 | 1: 1x3, 4-bit addr | 2: 1x1 | 3: default 14x14
  int R[4] = '{2, 1, 1, 14};
  int C[4] = '{3, 3, 1, 14};
  int P[4] = '{3, 3, 1, 14};
  int S[4] = '{1, 1, 1, 1};
  int W[4] = '{8, 4, 8, 8};

  int         sel = 0;
  logic       start = 1'b0, ready = 1'b0;
  logic [7:0] base = '0;

  logic [3:0] st_v, rd_v, vld_v, lst_v, bsy_v, dn_v;
  logic [7:0] addr_v [4];
  logic [3:0] row_v [4];
  logic [3:0] col_v [4];
  logic [3:0] addr1;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      st_v[i] = start && (sel == i);
      rd_v[i] = ready && (sel == i);
    end
  end

  down_counter_2d_rd #(.ROWS(2), .COLS(3), .ROW_W(4), .COL_W(4), .STRIDE(1), .ROW_PITCH(3), .ADDR_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .start_i(st_v[0]), .base_i(base), .addr_o(addr_v[0]),
    .valid_o(vld_v[0]), .ready_i(rd_v[0]), .row_o(row_v[0]), .col_o(col_v[0]),
    .last_o(lst_v[0]), .busy_o(bsy_v[0]), .done_o(dn_v[0]));

  down_counter_2d_rd #(.ROWS(1), .COLS(3), .ROW_W(4), .COL_W(4), .STRIDE(1), .ROW_PITCH(3), .ADDR_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start_i(st_v[1]), .base_i(base[3:0]), .addr_o(addr1),
    .valid_o(vld_v[1]), .ready_i(rd_v[1]), .row_o(row_v[1]), .col_o(col_v[1]),
    .last_o(lst_v[1]), .busy_o(bsy_v[1]), .done_o(dn_v[1]));
  assign addr_v[1] = {4'b0, addr1};

  down_counter_2d_rd #(.ROWS(1), .COLS(1), .ROW_W(4), .COL_W(4), .STRIDE(1), .ROW_PITCH(1), .ADDR_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .start_i(st_v[2]), .base_i(base), .addr_o(addr_v[2]),
    .valid_o(vld_v[2]), .ready_i(rd_v[2]), .row_o(row_v[2]), .col_o(col_v[2]),
    .last_o(lst_v[2]), .busy_o(bsy_v[2]), .done_o(dn_v[2]));

  down_counter_2d_rd u3 (
    .clk(clk), .rst_n(rst_n), .start_i(st_v[3]), .base_i(base), .addr_o(addr_v[3]),
    .valid_o(vld_v[3]), .ready_i(rd_v[3]), .row_o(row_v[3]), .col_o(col_v[3]),
    .last_o(lst_v[3]), .busy_o(bsy_v[3]), .done_o(dn_v[3]));

  // Observed bundle of the selected instance: {valid,busy,done,last,row,col,addr}
  function automatic logic [19:0] obs(int s);
    return {vld_v[s], bsy_v[s], dn_v[s], lst_v[s], row_v[s], col_v[s], addr_v[s]};
  endfunction

  typedef struct {
    logic [7:0] addr;
    logic [3:0] row;
    logic [3:0] col;
    logic       last;
  } beat_t;
  beat_t exp_q[$];

  int n_chk = 0;
  int n_fail = 0;

  // Reference: the tile as an ordered list of (row, col, address) beats.
  function automatic void build_exp(int s, int b);
    beat_t e;
    exp_q.delete();
    for (int r = R[s] - 1; r >= 0; r--)
      for (int c = C[s] - 1; c >= 0; c--) begin
        e.addr = 8'((b + r * P[s] + c * S[s]) % (1 << W[s]));
        e.row  = 4'(r);
        e.col  = 4'(c);
        e.last = (r == 0) && (c == 0);
        exp_q.push_back(e);
      end
  endfunction

  // Drives one tile. rmode: 0 ready always 1, 1 random, 2 hold ready low 3 cycles at addr 13.
  // inject: pulse start with base 0 while the tile is in flight and in DONE.
  task automatic run_tile(int s, int b, int rmode, bit inject);
    int stall = 0;
    int cyc = 0;
    logic [19:0] want;
    sel = s;
    build_exp(s, b);
    start = 1'b1; base = 8'(b);
    @(negedge clk);
    start = 1'b0; base = '0;
    while (exp_q.size() > 0 && cyc < 4000) begin
      want = {1'b1, 1'b1, 1'b0, exp_q[0].last, exp_q[0].row, exp_q[0].col, exp_q[0].addr};
      n_chk++;
      if (obs(s) !== want) begin
        n_fail++;
        $display("FAIL beat cfg%0d base%0d idx%0d: got %h want %h", s, b,
                 R[s] * C[s] - exp_q.size(), obs(s), want);
      end
      case (rmode)
        0: ready = 1'b1;
        1: ready = 1'($urandom_range(0, 1));
        default: begin
          if (exp_q[0].addr == 8'd13 && stall < 3) begin ready = 1'b0; stall++; end
          else ready = 1'b1;
        end
      endcase
      if (inject) start = 1'($urandom_range(0, 1));
      if (ready) void'(exp_q.pop_front());
      @(negedge clk);
      cyc++;
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL timeout cfg%0d: %0d beats left, want 0", s, exp_q.size());
    end
    ready = 1'b0;
    start = inject;
    n_chk++;
    if ({vld_v[s], bsy_v[s], dn_v[s]} !== 3'b011) begin
      n_fail++;
      $display("FAIL done_pulse cfg%0d: {valid,busy,done} got %b want 011", s, {vld_v[s], bsy_v[s], dn_v[s]});
    end
    @(negedge clk);
    start = 1'b0;
    n_chk++;
    if ({vld_v[s], bsy_v[s], dn_v[s]} !== 3'b000) begin
      n_fail++;
      $display("FAIL idle_after cfg%0d: {valid,busy,done} got %b want 000", s, {vld_v[s], bsy_v[s], dn_v[s]});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      n_chk++;
      if (obs(s) !== 20'h0) begin
        n_fail++;
        $display("FAIL reset cfg%0d: got %h want 00000", s, obs(s));
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();         run_tile(0, 10, 0, 1'b0); endtask
  task automatic test_backpressure();  run_tile(0, 10, 2, 1'b0); endtask
  task automatic test_wrap();          run_tile(1, 14, 0, 1'b0); endtask
  task automatic test_degenerate();    run_tile(2, 7, 1, 1'b0);  endtask

  task automatic test_start_while_busy();
    run_tile(0, 20, 1, 1'b1);
    run_tile(0, 30, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    sel = 0;
    build_exp(0, 40);
    start = 1'b1; base = 8'd40;
    @(negedge clk);
    start = 1'b0; ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (addr_v[0] !== exp_q[i].addr || vld_v[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL pre_reset beat%0d: addr %0d valid %b want %0d 1", i, addr_v[0], vld_v[0], exp_q[i].addr);
      end
      @(negedge clk);
    end
    rst_n = 1'b0; ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_chk++;
    if (obs(0) !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got %h want 00000", obs(0));
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++;
      if (dn_v[0] !== 1'b0 || bsy_v[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_no_done cyc%0d: done %b busy %b want 0 0", i, dn_v[0], bsy_v[0]);
      end
    end
    run_tile(0, 40, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++)
      run_tile(3, int'($urandom_range(0, 255)), 1, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_start_while_busy();
    test_reset_mid();
    test_degenerate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
